// File: rtl/cp0_nested_exc.sv
// cp0_nested_exc: MIPS-54 coprocessor 0 with a DEPTH-entry hardware stack of
// {Status, Cause, EPC} so that ERET unwinds nested handlers in LIFO order.
// Optional feature macro: CP0_TIMER_EN enables the Count(9)/Compare(11) timer,
// which raises IP7 on a match. Without it, regs 9 and 11 are plain storage.
module cp0_nested_exc #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned NUM_IRQ = 6,
    parameter logic [31:0] VECTOR  = 32'h0040_0004
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_ena,
    input  logic               i_mfc0,
    input  logic               i_mtc0,
    input  logic [4:0]         i_rd,
    input  logic [31:0]        i_wdata,
    input  logic [31:0]        i_npc,
    input  logic               i_exception,
    input  logic [4:0]         i_cause,
    input  logic               i_eret,
    input  logic [NUM_IRQ-1:0] i_irq,
    output logic [31:0]        o_rdata,
    output logic [31:0]        o_exc_addr,
    output logic               o_exc_taken,
    output logic               o_eret_taken,
    output logic               o_stack_ovf,
    output logic [3:0]         o_depth
);

    localparam int unsigned SpW  = $clog2(DEPTH + 1);
    // Stack storage is rounded up to a power of two so the index width matches exactly.
    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned StkN = 1 << IdxW;

    localparam logic [4:0]  RegCount   = 5'd9;
    localparam logic [4:0]  RegCompare = 5'd11;
    localparam logic [4:0]  RegStatus  = 5'd12;
    localparam logic [4:0]  RegCause   = 5'd13;
    localparam logic [4:0]  RegEpc     = 5'd14;
    localparam logic [31:0] StatusRst  = 32'h0000_FF0F;

    localparam logic [4:0]  CodeSyscall = 5'b01000;
    localparam logic [4:0]  CodeBreak   = 5'b01001;
    localparam logic [4:0]  CodeTeq     = 5'b01101;

    typedef enum logic [2:0] {
        ActNone,
        ActEret,
        ActEnter,
        ActOverflow,
        ActWrite
    } act_e;

    // Architectural state
    logic [31:0]    r_cp0 [32];
    logic [SpW-1:0] r_sp;
    logic [31:0]    r_exc_addr;
    logic           r_exc_taken;
    logic           r_eret_taken;
    logic           r_stack_ovf;

    // Saved context stack
    logic [31:0]    r_stk_status [StkN];
    logic [31:0]    r_stk_cause  [StkN];
    logic [31:0]    r_stk_epc    [StkN];

    // Next-state and decode
    logic [31:0]    w_cp0 [32];
    logic [SpW-1:0] w_sp;
    logic [31:0]    w_exc_addr;
    logic           w_exc_taken;
    logic           w_eret_taken;
    logic           w_stack_ovf;
    logic           w_push;

    logic [31:0]    w_status;
    logic [31:0]    w_cause;
    logic [31:0]    w_epc;
    logic           w_cause_en;
    logic           w_exc_req;
    logic           w_int_req;
    logic           w_full;
    logic           w_empty;
    logic           w_timer_hit;
    logic [7:0]     w_ip_set;
    logic [IdxW-1:0] w_push_idx;
    logic [IdxW-1:0] w_pop_idx;
    act_e           w_act;

    assign w_status   = r_cp0[RegStatus];
    assign w_cause    = r_cp0[RegCause];
    assign w_epc      = r_cp0[RegEpc];
    assign w_full     = (r_sp == SpW'(DEPTH));
    assign w_empty    = (r_sp == '0);
    assign w_push_idx = IdxW'(r_sp);
    assign w_pop_idx  = IdxW'(r_sp - SpW'(1));

`ifdef CP0_TIMER_EN
    assign w_timer_hit = (r_cp0[RegCompare] != 32'd0) &&
                         (r_cp0[RegCount] == r_cp0[RegCompare]);
`else
    assign w_timer_hit = 1'b0;
`endif

    // Sticky pending bits raised this cycle; the timer shares IP7 with irq[7].
    assign w_ip_set = 8'(i_irq) | {w_timer_hit, 7'd0};

    // Per-cause enable bit in Status; unknown codes are never enabled.
    always_comb begin
        w_cause_en = 1'b0;
        case (i_cause)
            CodeSyscall: w_cause_en = w_status[1];
            CodeBreak:   w_cause_en = w_status[2];
            CodeTeq:     w_cause_en = w_status[3];
            default:     w_cause_en = 1'b0;
        endcase
    end

    assign w_exc_req = i_exception && w_status[0] && w_cause_en;
    assign w_int_req = w_status[0] && (|(w_cause[15:8] & w_status[15:8]));

    // Pick the single action for this cycle: eret > exception > interrupt > mtc0.
    // A disabled or unknown exception is not an action, so lower requests still proceed.
    always_comb begin
        w_act = ActNone;
        if (i_eret) begin
            w_act = ActEret;
        end else if (w_exc_req || w_int_req) begin
            w_act = w_full ? ActOverflow : ActEnter;
        end else if (i_mtc0) begin
            w_act = ActWrite;
        end
    end

    // Next-state for the register file, stack pointer, redirect target and pulses.
    always_comb begin
        w_cp0        = r_cp0;
        w_sp         = r_sp;
        w_exc_addr   = r_exc_addr;
        w_exc_taken  = 1'b0;
        w_eret_taken = 1'b0;
        w_stack_ovf  = 1'b0;
        w_push       = 1'b0;
        if (i_ena) begin
`ifdef CP0_TIMER_EN
            w_cp0[RegCount] = r_cp0[RegCount] + 32'd1;
`endif
            unique case (w_act)
                ActEret: begin
                    w_exc_addr   = w_epc;
                    w_eret_taken = 1'b1;
                    if (!w_empty) begin
                        w_cp0[RegStatus] = r_stk_status[w_pop_idx];
                        w_cp0[RegCause]  = r_stk_cause[w_pop_idx];
                        w_cp0[RegEpc]    = r_stk_epc[w_pop_idx];
                        w_sp             = r_sp - SpW'(1);
                    end
                end
                ActEnter: begin
                    w_push                  = 1'b1;
                    w_cp0[RegEpc]           = i_npc;
                    w_cp0[RegCause][6:2]    = w_exc_req ? i_cause : 5'd0;
                    w_cp0[RegStatus][0]     = 1'b0;
                    w_exc_addr              = VECTOR;
                    w_sp                    = r_sp + SpW'(1);
                    w_exc_taken             = 1'b1;
                end
                ActOverflow: begin
                    w_stack_ovf = 1'b1;
                end
                ActWrite: begin
                    // A Count write lands after the increment above, so it wins.
                    w_cp0[i_rd] = i_wdata;
`ifdef CP0_TIMER_EN
                    if (i_rd == RegCompare) begin
                        w_cp0[RegCause][15] = 1'b0;
                    end
`endif
                end
                default: begin
                end
            endcase
            // Newly raised pending bits override any clear or restore in the same cycle.
            w_cp0[RegCause][15:8] = w_cp0[RegCause][15:8] | w_ip_set;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int i = 0; i < 32; i++) begin
                r_cp0[i] <= '0;
            end
            r_cp0[RegStatus] <= StatusRst;
            r_sp             <= '0;
            r_exc_addr       <= '0;
            r_exc_taken      <= 1'b0;
            r_eret_taken     <= 1'b0;
            r_stack_ovf      <= 1'b0;
        end else begin
            r_cp0        <= w_cp0;
            r_sp         <= w_sp;
            r_exc_addr   <= w_exc_addr;
            r_exc_taken  <= w_exc_taken;
            r_eret_taken <= w_eret_taken;
            r_stack_ovf  <= w_stack_ovf;
        end
    end

    // Context push on entry; entries above SP are dead, so no reset is needed.
    always_ff @(posedge i_clk) begin
        if (i_rst && w_push) begin
            r_stk_status[w_push_idx] <= w_status;
            r_stk_cause[w_push_idx]  <= w_cause;
            r_stk_epc[w_push_idx]    <= w_epc;
        end
    end

    assign o_rdata      = i_mfc0 ? r_cp0[i_rd] : 32'd0;
    assign o_exc_addr   = r_exc_addr;
    assign o_exc_taken  = r_exc_taken;
    assign o_eret_taken = r_eret_taken;
    assign o_stack_ovf  = r_stack_ovf;
    assign o_depth      = 4'(r_sp);

endmodule

// File: tb/tb_cp0_nested_exc.sv
// Bench for cp0_nested_exc: directed literal checks followed by randomized traffic,
// all compared every cycle against a queue-based behavioural model.
module tb_cp0_nested_exc;

    localparam int unsigned DEPTH   = 2;
    localparam int unsigned NUM_IRQ = 6;
    localparam logic [31:0] VECTOR  = 32'h0040_0004;

    logic               clk = 1'b0;
    logic               rst, ena, mfc0, mtc0, exception, eret;
    logic [4:0]         rd, cause;
    logic [31:0]        wdata, npc;
    logic [NUM_IRQ-1:0] irq;
    logic [31:0]        o_rdata, o_exc_addr;
    logic               o_exc_taken, o_eret_taken, o_stack_ovf;
    logic [3:0]         o_depth;

    int n_total = 0;
    int n_bad   = 0;

    cp0_nested_exc #(
        .DEPTH   (DEPTH),
        .NUM_IRQ (NUM_IRQ),
        .VECTOR  (VECTOR)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_ena        (ena),
        .i_mfc0       (mfc0),
        .i_mtc0       (mtc0),
        .i_rd         (rd),
        .i_wdata      (wdata),
        .i_npc        (npc),
        .i_exception  (exception),
        .i_cause      (cause),
        .i_eret       (eret),
        .i_irq        (irq),
        .o_rdata      (o_rdata),
        .o_exc_addr   (o_exc_addr),
        .o_exc_taken  (o_exc_taken),
        .o_eret_taken (o_eret_taken),
        .o_stack_ovf  (o_stack_ovf),
        .o_depth      (o_depth)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] st;
        logic [31:0] ca;
        logic [31:0] ep;
    } frame_t;

    logic [31:0] m_reg [32];
    frame_t      m_stack [$];
    logic [31:0] m_exc_addr;
    bit          m_exc_taken, m_eret_taken, m_ovf, m_valid = 0;

    task automatic model_step();
        logic [31:0] st, ca, ep;
        logic [7:0]  ipset;
        bit          en_bit, exc_ok, int_ok;
        frame_t      fr;
        m_exc_taken  = 0;
        m_eret_taken = 0;
        m_ovf        = 0;
        if (!rst) begin
            foreach (m_reg[i]) m_reg[i] = 32'd0;
            m_reg[12]  = 32'h0000_FF0F;
            m_stack.delete();
            m_exc_addr = 32'd0;
            m_valid    = 1;
            return;
        end
        if (!ena) return;
        st    = m_reg[12];
        ca    = m_reg[13];
        ep    = m_reg[14];
        ipset = 8'(irq);
`ifdef CP0_TIMER_EN
        if (m_reg[11] != 0 && m_reg[9] == m_reg[11]) ipset[7] = 1'b1;
        m_reg[9] = m_reg[9] + 1;
`endif
        case (cause)
            5'd8:    en_bit = st[1];
            5'd9:    en_bit = st[2];
            5'd13:   en_bit = st[3];
            default: en_bit = 0;
        endcase
        exc_ok = exception && st[0] && en_bit;
        int_ok = st[0] && ((ca[15:8] & st[15:8]) != 8'd0);
        if (eret) begin
            m_exc_addr   = ep;
            m_eret_taken = 1;
            if (m_stack.size() > 0) begin
                fr        = m_stack.pop_back();
                m_reg[12] = fr.st;
                m_reg[13] = fr.ca;
                m_reg[14] = fr.ep;
            end
        end else if (exc_ok || int_ok) begin
            if (m_stack.size() >= DEPTH) begin
                m_ovf = 1;
            end else begin
                m_stack.push_back('{st: st, ca: ca, ep: ep});
                m_reg[14]      = npc;
                m_reg[13][6:2] = exc_ok ? cause : 5'd0;
                m_reg[12][0]   = 1'b0;
                m_exc_addr     = VECTOR;
                m_exc_taken    = 1;
            end
        end else if (mtc0) begin
            m_reg[rd] = wdata;
`ifdef CP0_TIMER_EN
            if (rd == 5'd11) m_reg[13][15] = 1'b0;
`endif
        end
        m_reg[13][15:8] = m_reg[13][15:8] | ipset;
    endtask

    // Advance the model on each edge, then compare settled outputs.
    always @(posedge clk) begin
        model_step();
        #2;
        if (m_valid) begin
            check("rdata", o_rdata, mfc0 ? m_reg[rd] : 32'd0);
            check("exc_addr", o_exc_addr, m_exc_addr);
            check("exc_taken", 32'(o_exc_taken), 32'(m_exc_taken));
            check("eret_taken", 32'(o_eret_taken), 32'(m_eret_taken));
            check("stack_ovf", 32'(o_stack_ovf), 32'(m_ovf));
            check("depth", 32'(o_depth), 32'(m_stack.size()));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        ena = 1; mfc0 = 0; mtc0 = 0; rd = 0; wdata = 0; npc = 0;
        exception = 0; cause = 0; eret = 0; irq = '0;
    endtask

    task automatic peek(input logic [4:0] r, output logic [31:0] v);
        mfc0 = 1;
        rd   = r;
        #1;
        v = o_rdata;
    endtask

    task automatic do_mtc0(input logic [4:0] r, input logic [31:0] d);
        idle(); mtc0 = 1; rd = r; wdata = d; tick(); idle();
    endtask

    task automatic do_exc(input logic [4:0] c, input logic [31:0] pc);
        idle(); exception = 1; cause = c; npc = pc; tick(); idle();
    endtask

    task automatic do_eret();
        idle(); eret = 1; tick(); idle();
    endtask

    initial begin
        logic [31:0] v;
        rst = 0;
        idle();
        tick(); tick();
        rst = 1;

        // Reset values
        peek(12, v); check("rst_status", v, 32'h0000_FF0F);
        check("rst_depth", 32'(o_depth), 32'd0);
        check("rst_exc_addr", o_exc_addr, 32'd0);

        // SYSCALL entry and return
        do_exc(5'b01000, 32'h0040_0120);
        check("sys_taken", 32'(o_exc_taken), 32'd1);
        check("sys_addr", o_exc_addr, 32'h0040_0004);
        check("sys_depth", 32'(o_depth), 32'd1);
        peek(14, v); check("sys_epc", v, 32'h0040_0120);
        peek(13, v); check("sys_cause", v, 32'h0000_0020);
        peek(12, v); check("sys_status", v, 32'h0000_FF0E);
        do_eret();
        check("ret_taken", 32'(o_eret_taken), 32'd1);
        check("ret_addr", o_exc_addr, 32'h0040_0120);
        check("ret_depth", 32'(o_depth), 32'd0);
        peek(12, v); check("ret_status", v, 32'h0000_FF0F);

        // Nesting to overflow with DEPTH=2
        do_exc(5'b01000, 32'h0040_1000);
        check("nest1_depth", 32'(o_depth), 32'd1);
        do_mtc0(12, 32'h0000_FF0F);
        do_exc(5'b01000, 32'h0040_2000);
        check("nest2_depth", 32'(o_depth), 32'd2);
        do_mtc0(12, 32'h0000_FF0F);
        do_exc(5'b01000, 32'h0040_3000);
        check("ovf_pulse", 32'(o_stack_ovf), 32'd1);
        check("ovf_no_entry", 32'(o_exc_taken), 32'd0);
        check("ovf_depth", 32'(o_depth), 32'd2);
        peek(14, v); check("ovf_epc", v, 32'h0040_2000);
        do_eret();
        check("unwind1_addr", o_exc_addr, 32'h0040_2000);
        check("unwind1_depth", 32'(o_depth), 32'd1);
        peek(14, v); check("unwind1_epc", v, 32'h0040_1000);
        do_eret();
        check("unwind2_addr", o_exc_addr, 32'h0040_1000);
        check("unwind2_depth", 32'(o_depth), 32'd0);

        // Interrupt on irq[2]
        idle(); irq = 6'b000100; tick(); idle();
        peek(13, v); check("irq_ip2", v, 32'h0000_0400);
        idle(); npc = 32'h0040_0200; tick(); idle();
        check("irq_taken", 32'(o_exc_taken), 32'd1);
        check("irq_depth", 32'(o_depth), 32'd1);
        peek(13, v); check("irq_cause", v, 32'h0000_0400);
        peek(14, v); check("irq_epc", v, 32'h0040_0200);
        do_mtc0(13, 32'd0);
        peek(13, v); check("ip_clear", v, 32'd0);
        idle(); exception = 1; cause = 5'b01000; eret = 1; tick(); idle();
        check("prio_eret", 32'(o_eret_taken), 32'd1);
        check("prio_no_exc", 32'(o_exc_taken), 32'd0);
        check("prio_depth", 32'(o_depth), 32'd0);

        // Disabled and unknown causes
        rst = 0; tick(); rst = 1;
        do_mtc0(12, 32'h0000_FF0B);
        do_exc(5'b01001, 32'h0040_0300);
        check("brk_off_pulse", 32'(o_exc_taken), 32'd0);
        check("brk_off_depth", 32'(o_depth), 32'd0);
        peek(14, v); check("brk_off_epc", v, 32'd0);
        peek(13, v); check("brk_off_cause", v, 32'd0);
        do_mtc0(12, 32'h0000_FF0F);
        do_exc(5'b00011, 32'h0040_0400);
        check("unk_pulse", 32'(o_exc_taken), 32'd0);
        check("unk_depth", 32'(o_depth), 32'd0);

        // Timer / plain storage for Count and Compare
        do_mtc0(12, 32'h0000_FF0E);
        do_mtc0(9, 32'd0);
        do_mtc0(11, 32'd5);
        repeat (4) tick();
`ifdef CP0_TIMER_EN
        peek(13, v); check("tmr_before", v, 32'd0);
        idle(); tick();
        peek(13, v); check("tmr_hit", v, 32'h0000_8000);
        peek(9, v); check("tmr_count", v, 32'd6);
        do_mtc0(11, 32'd0);
        peek(13, v); check("tmr_clear", v, 32'd0);
`else
        peek(9, v); check("count_static", v, 32'd0);
        peek(11, v); check("compare_store", v, 32'd5);
        peek(13, v); check("no_ip7", v, 32'd0);
`endif

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom_range(0, 299) != 0);
            ena       = ($urandom_range(0, 7) != 0);
            eret      = ($urandom_range(0, 9) == 0);
            exception = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 4))
                0:       cause = 5'd8;
                1:       cause = 5'd9;
                2:       cause = 5'd13;
                3:       cause = 5'd3;
                default: cause = 5'($urandom);
            endcase
            npc  = $urandom & 32'hFFFF_FFFC;
            mtc0 = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0:       rd = 5'd12;
                1:       rd = 5'd13;
                2:       rd = 5'd14;
                3:       rd = 5'd9;
                4:       rd = 5'd11;
                default: rd = 5'($urandom);
            endcase
            wdata = $urandom;
            if (rd == 5'd12 && $urandom_range(0, 1) == 1) wdata[0] = 1'b1;
            irq  = ($urandom_range(0, 5) == 0) ? NUM_IRQ'($urandom) : '0;
            mfc0 = 1'($urandom_range(0, 1));
            tick();
        end

        idle();
        tick(); tick();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
